// File: rtl/unidade_adiantamento.sv
// Forwarding and load-use hazard unit: owns the EX/MEM and MEM/WB forwarding
// registers and drives the EX operand mux select plus its two bypass inputs.
module unidade_adiantamento #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned REG_AW = 3
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic              ex_escreve,
   input  logic              ex_le_mem,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic [DATA_W-1:0] ex_resultado,
   input  logic [DATA_W-1:0] mem_dado,
   output logic [1:0]        select,
   output logic [DATA_W-1:0] data1,
   output logic [DATA_W-1:0] data2,
   output logic              stall,
   output logic [15:0]       conta_bolhas
);

   localparam int unsigned SEL_W = 2;
   localparam int unsigned CNT_W = 16;
   localparam logic [SEL_W-1:0] SEL_RF = 2'b00;
   localparam logic [SEL_W-1:0] SEL_EM = 2'b01;
   localparam logic [SEL_W-1:0] SEL_MW = 2'b10;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [REG_AW-1:0] em_rd;
   logic              em_escreve;
   logic              em_le_mem;
   logic [DATA_W-1:0] em_valor;
   logic [REG_AW-1:0] mw_rd;
   logic              mw_escreve;
   logic [DATA_W-1:0] mw_valor;
   logic [SEL_W-1:0]  select_next;
   logic              rs_nonzero;

   assign rs_nonzero = (id_rs != '0);

   // Load in EX feeding the instruction in ID; gated by reset so it drops at once.
   assign stall = reset & id_valid & ex_escreve & ex_le_mem & (ex_rd == id_rs) & rs_nonzero;

   // Newest producer wins: EX beats EX/MEM.
   always_comb begin
      select_next = SEL_RF;
      if (!stall && id_valid && rs_nonzero) begin
         if (ex_escreve && (ex_rd == id_rs)) begin
            select_next = SEL_EM;
         end else if (em_escreve && (em_rd == id_rs)) begin
            select_next = SEL_MW;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         em_rd      <= '0;
         em_escreve <= 1'b0;
         em_le_mem  <= 1'b0;
         em_valor   <= '0;
         mw_rd      <= '0;
         mw_escreve <= 1'b0;
         mw_valor   <= '0;
      end else begin
         em_rd      <= ex_rd;
         em_escreve <= ex_escreve;
         em_le_mem  <= ex_le_mem;
         em_valor   <= ex_resultado;
         mw_rd      <= em_rd;
         mw_escreve <= em_escreve;
         mw_valor   <= em_le_mem ? mem_dado : em_valor;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         select <= SEL_RF;
      end else begin
         select <= select_next;
      end
   end

   // Saturating stall-cycle counter.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         conta_bolhas <= '0;
      end else if (stall && (conta_bolhas != CNT_MAX)) begin
         conta_bolhas <= conta_bolhas + CNT_W'(1);
      end
   end

   assign data1 = em_valor;
   assign data2 = mw_valor;

   // MEM/WB destination is kept for completeness of the pipeline image.
   logic unused_mw;
   assign unused_mw = ^{mw_rd, mw_escreve};

endmodule

// File: tb/tb_unidade_adiantamento.sv
// Directed self-checking bench for unidade_adiantamento.
module tb_unidade_adiantamento;

   logic        clock;
   logic        reset;
   logic        id_valid;
   logic [2:0]  id_rs;
   logic        ex_escreve;
   logic        ex_le_mem;
   logic [2:0]  ex_rd;
   logic [15:0] ex_resultado;
   logic [15:0] mem_dado;
   logic [1:0]  select;
   logic [15:0] data1;
   logic [15:0] data2;
   logic        stall;
   logic [15:0] conta_bolhas;

   int tests;
   int fails;

   unidade_adiantamento #(.DATA_W(16), .REG_AW(3)) dut (
      .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs(id_rs),
      .ex_escreve(ex_escreve), .ex_le_mem(ex_le_mem), .ex_rd(ex_rd),
      .ex_resultado(ex_resultado), .mem_dado(mem_dado), .select(select),
      .data1(data1), .data2(data2), .stall(stall), .conta_bolhas(conta_bolhas)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic v, input logic [2:0] rs, input logic w, input logic ld,
                        input logic [2:0] rd, input logic [15:0] res);
      id_valid = v; id_rs = rs; ex_escreve = w; ex_le_mem = ld; ex_rd = rd; ex_resultado = res;
   endtask

   initial begin
      tests = 0;
      fails = 0;
      mem_dado = 16'hDEAD;
      reset = 1'b0;
      drive(1'b1, 3'd2, 1'b1, 1'b1, 3'd2, 16'h9999);
      step(); step();
      #1;
      chk("rst_stall",  32'(stall), 32'h0);
      chk("rst_select", 32'(select), 32'h0);
      chk("rst_data1",  32'(data1), 32'h0);
      chk("rst_data2",  32'(data2), 32'h0);
      chk("rst_count",  32'(conta_bolhas), 32'h0);

      drive(1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 16'h0000);
      reset = 1'b1;
      step();
      chk("post_rel_select", 32'(select), 32'h0);

      // distance 1
      drive(1'b1, 3'd3, 1'b1, 1'b0, 3'd3, 16'h1234);
      #1 chk("d1_stall", 32'(stall), 32'h0);
      step();
      chk("d1_select", 32'(select), 32'h1);
      chk("d1_data1",  32'(data1), 32'h1234);

      // priority: EX/MEM r5=AAAA, EX r5=5555
      drive(1'b0, 3'd0, 1'b1, 1'b0, 3'd5, 16'hAAAA);
      step();
      drive(1'b1, 3'd5, 1'b1, 1'b0, 3'd5, 16'h5555);
      step();
      chk("prio_select", 32'(select), 32'h1);
      chk("prio_data1",  32'(data1), 32'h5555);
      chk("prio_data2",  32'(data2), 32'hAAAA);

      // distance 2
      drive(1'b0, 3'd0, 1'b1, 1'b0, 3'd6, 16'h0606);
      step();
      drive(1'b1, 3'd6, 1'b0, 1'b0, 3'd0, 16'h0000);
      step();
      chk("d2_select", 32'(select), 32'h2);
      chk("d2_data2",  32'(data2), 32'h0606);

      // load-use
      drive(1'b1, 3'd2, 1'b1, 1'b1, 3'd2, 16'h0F0F);
      #1 chk("lu_stall", 32'(stall), 32'h1);
      step();
      drive(1'b1, 3'd2, 1'b0, 1'b0, 3'd0, 16'h0000);
      mem_dado = 16'hBEEF;
      #1;
      chk("lu_bubble_stall",  32'(stall), 32'h0);
      chk("lu_bubble_select", 32'(select), 32'h0);
      step();
      chk("lu_select", 32'(select), 32'h2);
      chk("lu_data2",  32'(data2), 32'hBEEF);
      chk("lu_count",  32'(conta_bolhas), 32'h1);

      // r0 and no-write
      drive(1'b1, 3'd0, 1'b1, 1'b1, 3'd0, 16'h7777);
      #1 chk("r0_stall", 32'(stall), 32'h0);
      step();
      chk("r0_select", 32'(select), 32'h0);
      drive(1'b1, 3'd4, 1'b0, 1'b0, 3'd4, 16'h4444);
      #1 chk("nowr_stall", 32'(stall), 32'h0);
      step();
      chk("nowr_select", 32'(select), 32'h0);
      chk("nowr_count",  32'(conta_bolhas), 32'h1);

      // reset mid-stall
      drive(1'b1, 3'd1, 1'b1, 1'b1, 3'd1, 16'h1111);
      #1;
      chk("ms_data1_pre", 32'(data1), 32'h4444);
      chk("ms_stall_pre", 32'(stall), 32'h1);
      #1 reset = 1'b0;
      #1;
      chk("ms_stall",  32'(stall), 32'h0);
      chk("ms_data1",  32'(data1), 32'h0);
      chk("ms_data2",  32'(data2), 32'h0);
      chk("ms_count",  32'(conta_bolhas), 32'h0);
      chk("ms_select", 32'(select), 32'h0);
      step();
      chk("ms_hold_count", 32'(conta_bolhas), 32'h0);
      reset = 1'b1;

      // saturation
      drive(1'b1, 3'd7, 1'b1, 1'b1, 3'd7, 16'h0000);
      for (int i = 0; i < 65534; i++) step();
      chk("sat_pre",   32'(conta_bolhas), 32'hFFFE);
      for (int i = 0; i < 3; i++) step();
      chk("sat_count", 32'(conta_bolhas), 32'hFFFF);
      chk("sat_stall", 32'(stall), 32'h1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/unidade_adiantamento.md
# unidade_adiantamento

- Forwarding and load-use hazard unit for the 16-bit pipelined datapath.
- Sits directly upstream of the EX-stage 3-to-1 operand mux and drives all three of its non-register inputs: the 2-bit select, the EX/MEM value (data1) and the MEM/WB value (data2). The mux's data0 stays the register-file read value.
- Keeps its own EX/MEM and MEM/WB destination/value registers, so it is the single source of forwarded operands.
- Raises a one-cycle stall on load-use hazards.

## Interface

Parameters:
- DATA_W, 16, operand/result width
- REG_AW, 3, register address width (8 registers, r0 hardwired zero)

Ports:
- clock  in  1  single clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- id_valid  in  1  an instruction in ID will issue to EX at the next edge, unless stalled
- id_rs  in  REG_AW  source register read by that ID instruction
- ex_escreve  in  1  instruction now in EX writes a register (0 for a bubble)
- ex_le_mem  in  1  instruction now in EX is a load
- ex_rd  in  REG_AW  destination register of the instruction in EX
- ex_resultado  in  DATA_W  ALU result of the instruction in EX
- mem_dado  in  DATA_W  memory read data for the instruction held in EX/MEM
- select  out  2  registered mux select: 00 = register file, 01 = data1, 10 = data2; 11 is never driven
- data1  out  DATA_W  EX/MEM forwarded value (registered)
- data2  out  DATA_W  MEM/WB forwarded value (registered)
- stall  out  1  combinational load-use stall request to the PC/IF/ID and the bubble logic
- conta_bolhas  out  16  saturating count of stall cycles

## Operation

Internal registers:
- EX/MEM: em_rd, em_escreve, em_le_mem, em_valor
- MEM/WB: mw_rd, mw_escreve, mw_valor

Every rising edge, with reset high:
- EX/MEM captures ex_rd, ex_escreve, ex_le_mem and ex_resultado.
- MEM/WB captures em_rd and em_escreve; mw_valor captures mem_dado if em_le_mem = 1, else em_valor.
- data1 = em_valor and data2 = mw_valor, driven directly from the registers.

Stall (combinational):
- stall = id_valid & ex_escreve & ex_le_mem & (ex_rd == id_rs) & (id_rs != 0); forced 0 while reset = 0.
- Upstream holds ID and drives a bubble (ex_escreve = 0) into EX at the next edge.
- The pipeline registers in this block advance normally during a stall.

Select (registered), computed at the edge from pre-edge values:
- Forced to 00 when stall = 1, id_valid = 0, or id_rs = 0.
- Otherwise 01 if ex_escreve & (ex_rd == id_rs). This is the newest producer and always wins.
- Otherwise 10 if em_escreve & (em_rd == id_rs).
- Otherwise 00.
- Hazards at distance ≥ 3 are resolved by the register file's write-before-read; this block does not cover them.

Counter:
- conta_bolhas increments by 1 at each edge where stall = 1.
- It holds at 0xFFFF and does not wrap.

## Timing

- Reset (reset = 0, asynchronous): select = 00, data1 = 0, data2 = 0, conta_bolhas = 0, stall = 0, all valid/escreve bits = 0. Operation resumes at the first edge after release.
- ALU dependency, distance 1: producer in EX at edge t-1 → dependent enters EX at t with select = 01, data1 = producer result. Zero stall.
- Distance 2: select = 10 and data2 = producer value, in the dependent's EX cycle.
- Load followed by an immediate dependent:
  - stall = 1 during the cycle the load is in EX.
  - At the next edge: the bubble enters EX, select = 00, the load moves to EX/MEM.
  - At the following edge: the dependent enters EX with select = 10 and data2 = mem_dado.
  - Total penalty: exactly one cycle.
- Load at distance 2: no stall; select = 10, data2 = load data.
- Both EX and EX/MEM write id_rs: select = 01.
- Reset asserted mid-stall: stall drops immediately; no count is added for the interrupted cycle.

## Test plan

- Reset: drive reset = 0 with arbitrary inputs → select = 00, data1 = data2 = 0, stall = 0, conta_bolhas = 0, both asynchronously and after release.
- Distance-1 forwarding: EX = {rd = 3, escreve = 1, resultado = 0x1234}, id_rs = 3, id_valid = 1 → next cycle select = 01, data1 = 0x1234.
- Priority: EX/MEM writes r5 = 0xAAAA and EX writes r5 = 0x5555, id_rs = 5 → select = 01, data1 = 0x5555.
- Load-use: load in EX {rd = 2, le_mem = 1}, id_rs = 2 → stall = 1 for one cycle, then bubble with select = 00; next cycle with mem_dado = 0xBEEF → select = 10, data2 = 0xBEEF; conta_bolhas = 1.
- r0 and no-write: id_rs = 0 with EX rd = 0 writing, and separately EX rd = 4 with escreve = 0 and id_rs = 4 → select = 00, stall = 0.
- Saturation: preload 0xFFFE stall cycles (or force-deposit), then 3 more stall cycles → conta_bolhas = 0xFFFF.
